// File: rtl/div_unit.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish straight from IDLE.

module i_adder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        add_sub_i,
  input  logic        carry_i,
  output logic [31:0] sum_o,
  output logic        carry_o
);
  logic [31:0] b_eff;
  assign b_eff = add_sub_i ? ~b_i : b_i;
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {32'b0, carry_i};
endmodule

module div_unit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic [31:0] bmag_q, bmag_d, rem_q, rem_d, quo_q, quo_d, res_q, res_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, partial, trial, q_fix, r_fix;
  logic        no_borrow;

  assign a_neg   = ~op_i[0] & a_i[31];
  assign b_neg   = ~op_i[0] & b_i[31];
  assign a_mag   = a_neg ? (~a_i + 32'd1) : a_i;
  assign b_mag   = b_neg ? (~b_i + 32'd1) : b_i;
  assign partial = {rem_q[30:0], quo_q[31]};

  i_adder u_sub (
    .a_i       (partial),
    .b_i       (bmag_q),
    .add_sub_i (1'b1),
    .carry_i   (1'b1),
    .sum_o     (trial),
    .carry_o   (no_borrow)
  );

  // Quotient is not negated for b==0 so it stays all-ones for both signed and unsigned ops.
  assign q_fix = (~op_q[0] & (sa_q ^ sb_q) & ~bz_q) ? (~quo_q + 32'd1) : quo_q;
  assign r_fix = (~op_q[0] & sa_q) ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    bmag_d  = bmag_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            op_d    = op_i;
            sa_d    = a_neg;
            sb_d    = b_neg;
            bz_d    = (b_i == '0);
            bmag_d  = b_mag;
            rem_d   = '0;
            quo_d   = a_mag;
            cnt_d   = 5'd31;
            state_d = CALC;
`ifdef DIV_EARLY_OUT_EN
            if (b_i == '0) begin
              res_d   = op_i[1] ? a_i : '1;
              state_d = DONE;
            end else if (op_i == 2'b00 && a_i == 32'h8000_0000 && b_i == '1) begin
              res_d   = 32'h8000_0000;
              state_d = DONE;
            end
`endif
          end
        end
        CALC: begin
          rem_d = no_borrow ? trial : partial;
          quo_d = {quo_q[30:0], no_borrow};
          if (cnt_q == 5'd0) state_d = FIX;
          else               cnt_d   = cnt_q - 5'd1;
        end
        FIX: begin
          res_d   = op_q[1] ? r_fix : q_fix;
          state_d = DONE;
        end
        DONE: begin
          if (ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      bmag_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      bmag_q  <= bmag_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q != IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = res_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus handshake, flush and reset sequences.

module tb_div_unit;
  logic        clk, rst_n, valid_i, ready_o, flush_i, valid_o, ready_i, busy_o;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i, result_o;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives a request, returns after the negedge following the accept edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  function automatic int exp_lat(input bit special);
`ifdef DIV_EARLY_OUT_EN
    return special ? 1 : 34;
`else
    return 34;
`endif
  endfunction

  vec_t vecs[15];

  initial begin
    int lat;
    logic [31:0] held;
    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[5]  = '{2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1};
    vecs[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[8]  = '{2'b01, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[9]  = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  1'b0};
    vecs[10] = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          1'b0};
    vecs[11] = '{2'b00, 32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA,  1'b0};
    vecs[12] = '{2'b10, 32'd20,         32'hFFFF_FFFD,  32'd2,          1'b0};
    vecs[13] = '{2'b10, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE,  1'b0};
    vecs[14] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};

    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_busy",  32'(busy_o),  32'd0);
    check("reset_result", result_o, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_busy", i), 32'(busy_o | valid_o), 32'd1);
      wait_valid(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].special)));
      check($sformatf("vec%0d_result", i), result_o, vecs[i].exp);
      consume();
      check($sformatf("vec%0d_idle", i), {29'd0, ready_o, busy_o, valid_o}, 32'b100);
    end

    // Back-pressure in DONE, with a stray request pulse that must be ignored.
    start_op(2'b01, 32'd100, 32'd7);
    wait_valid(lat);
    held = result_o;
    check("hold_result", held, 32'd14);
    for (int c = 0; c < 10; c++) begin
      valid_i = (c == 4); op_i = 2'b01; a_i = 32'd9; b_i = 32'd3;
      @(negedge clk);
      check($sformatf("hold%0d", c), {28'd0, valid_o, ready_o, busy_o, 1'b0}, 32'b1010);
      check($sformatf("hold%0d_result", c), result_o, held);
    end
    valid_i = 1'b0;
    consume();
    check("hold_exit", {29'd0, ready_o, busy_o, valid_o}, 32'b100);

    // Flush mid-calculation.
    start_op(2'b01, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_idle", {29'd0, ready_o, busy_o, valid_o}, 32'b100);
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (valid_o) seen++;
      end
      check("flush_no_valid", 32'(seen), 32'd0);
    end

    // Normal op after flush, then reset mid-operation.
    start_op(2'b00, 32'hFFFF_FF9C, 32'd7);
    wait_valid(lat);
    check("post_flush_lat", 32'(lat), 32'd34);
    check("post_flush_res", result_o, 32'hFFFF_FFF2);
    consume();
    start_op(2'b11, 32'd12345, 32'd100);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_flags", {29'd0, ready_o, busy_o, valid_o}, 32'b100);
    check("rst_mid_result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (valid_o) seen++;
      end
      check("rst_no_valid", 32'(seen), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

- Sequential radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU instructions.
- Works in the opposite direction to the multiply path: one trial subtraction per cycle, using an `i_adder` instance in subtract mode.
- Sits beside the combinational ALU in execute and is driven over a valid/ready handshake.
- Stalls the pipeline via `busy_o` while iterating.

## Interface
Parameters:
- none; datapath width is fixed at 32 bits to match `i_adder`.

Ports:
- clk_i  in  1  clock. The whole block is single-clock.
- rst_ni  in  1  reset. Asynchronous assert, active-low.
- valid_i  in  1  request valid.
- ready_o  out  1  block can accept a request (IDLE only).
- op_i  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- a_i  in  32  dividend.
- b_i  in  32  divisor.
- flush_i  in  1  synchronous abort; discards any in-flight operation.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- result_o  out  32  quotient (op_i[1]=0) or remainder (op_i[1]=1).
- busy_o  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE**
  - ready_o=1.
  - On valid_i&&ready_o, latch op_i, sign(a_i), sign(b_i) and b_i==0.
  - Latch operand magnitudes: for signed ops, two's-complement absolute values; otherwise raw values.
  - Clear remainder, load quotient register with |a|, set count=31, go to CALC.
- **CALC**, one iteration per cycle:
  - Form partial = {rem[30:0], q[31]}.
  - Trial = partial − |b| through `i_adder` with add_sub=1 and carry_in=1; C=1 means no borrow.
  - If C=1: rem=trial, shift 1 into q. Else: rem=partial, shift 0 into q.
  - After the iteration with count=0, go to FIX; otherwise decrement count.
- **FIX**
  - Signed op: negate q when sign(a)≠sign(b) and b≠0; negate rem when sign(a)=1.
  - Select q or rem into the output register, go to DONE.
- **DONE**
  - valid_o=1 and result_o stays stable until valid_o&&ready_i, then return to IDLE.
  - A new request cannot be accepted in the same cycle (ready_o=0 in DONE).
- **Special cases** (fall out of the algorithm plus the FIX rule above):
  - b=0: quotient 0xFFFFFFFF, remainder a_i, for both signed and unsigned ops.
  - DIV with a=0x80000000, b=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- **flush_i** in any state forces IDLE next cycle and discards the result; valid_o drops the next cycle.
  - flush_i takes priority over acceptance and over the result handshake.
- **Reset values:** state=IDLE, ready_o=1, valid_o=0, busy_o=0, result_o=0, internal registers 0.

## Timing
- Request accepted on edge t.
- CALC occupies cycles t+1..t+32 and FIX occupies t+33.
- valid_o is high from t+34 until consumed: latency 34 cycles.
- Throughput is one operation per 35 cycles minimum (DONE→IDLE costs one cycle).
- busy_o rises at t+1 and falls on the cycle the block re-enters IDLE.
- Reset asserted mid-operation returns the block to IDLE immediately; no partial result is ever presented.
- valid_i is ignored while ready_o=0. Inputs need only be stable in the accept cycle.

## Configuration
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, b_i==0, or op=DIV with a=0x80000000 and b=0xFFFFFFFF, goes directly to DONE.
  - The special-case result is loaded there, and valid_o rises at t+1.
  - All other requests keep the 34-cycle latency.
- Undefined: every request takes 34 cycles.
- Results are bit-identical in both builds.

## Test plan
- DIVU a=100, b=7 -> result 14; REMU same operands -> 2; valid_o at exactly t+34.
- DIV a=−7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD (−3); REM same operands -> 0xFFFFFFFF (−1).
- DIV a=5, b=0 -> 0xFFFFFFFF; REM a=−5, b=0 -> 0xFFFFFFFB. Latency is t+34, or t+1 with DIV_EARLY_OUT_EN.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Hold ready_i=0 for 10 cycles in DONE -> valid_o and result_o stay stable; ready_o stays 0; a valid_i pulse is not accepted.
- Assert flush_i at t+10 -> IDLE at t+11 with valid_o never high; rst_ni low at t+20 of a new op -> all outputs at reset values at once.
